// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: takes one word per valid/ready handshake, gates the baudrate
// generator on for exactly one frame and serialises start, data (LSB first), parity and stop bits.
module uart_tx_ctrl #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] I_tx_data,
  input  logic              I_tx_valid,
  output logic              O_tx_ready,
  output logic              O_baudrate_tx_clk_en,
  input  logic              I_baudrate_tx_clk,
  output logic              O_txd,
  output logic              O_tx_busy,
  output logic              O_tx_done
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic ODD_SENSE = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              parity_q, parity_d;
  logic              txd_q, txd_d;
  logic              ready_q, ready_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Every output is the registered copy of the value computed for the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    txd_d      = txd_q;
    ready_d    = ready_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      // Ticks are ignored here, including one that coincides with the handshake.
      S_IDLE: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        if (I_tx_valid && ready_q) begin
          shift_d  = I_tx_data;
          parity_d = (^I_tx_data) ^ ODD_SENSE;
          state_d  = S_START;
          txd_d    = 1'b0;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end

      S_START: begin
        if (I_baudrate_tx_clk) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end

      // The line shows the next shift_q[0], which is the current shift_q[1].
      S_DATA: begin
        if (I_baudrate_tx_clk) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d    = S_STOP;
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            txd_d     = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (I_baudrate_tx_clk) begin
          state_d    = S_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end

      S_STOP: begin
        txd_d = 1'b1;
        if (I_baudrate_tx_clk) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        ready_d = 1'b1;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign O_txd                = txd_q;
  assign O_tx_ready           = ready_q;
  assign O_baudrate_tx_clk_en = en_q;
  assign O_tx_busy            = busy_q;
  assign O_tx_done            = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: five configurations run in parallel, each with its own
// baudrate model, expected-word queue and cycle-accurate line monitor.
module tb_uart_tx_ctrl;

  localparam int NI = 5;
  localparam int CFG_DW  [NI] = '{8, 8, 8, 8, 7};
  localparam int CFG_PE  [NI] = '{0, 1, 1, 0, 1};
  localparam int CFG_ODD [NI] = '{0, 0, 1, 0, 1};
  localparam int CFG_SB  [NI] = '{1, 1, 1, 2, 2};
  localparam int BIT_CLKS = 16;

  logic       clk;
  logic       rst      [NI];
  logic       valid    [NI];
  logic [8:0] tx_data  [NI];
  logic       inj_tick [NI];
  logic       tick     [NI];
  logic       ready    [NI];
  logic       en       [NI];
  logic       txd      [NI];
  logic       busy     [NI];
  logic       done     [NI];
  int         pending  [NI];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input int idx, input string name,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL inst%0d %s: actual=%0h required=%0h (t=%0t)", idx, name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int DW  = CFG_DW[g];
    localparam int PE  = CFG_PE[g];
    localparam int ODD = CFG_ODD[g];
    localparam int SB  = CFG_SB[g];

    logic [3:0]  gen_cnt;
    logic        rst_q;
    logic [8:0]  exp_q[$];
    logic [8:0]  w;
    logic [15:0] fb;
    logic [4:0]  act;
    int          cyc;
    int          flen;
    bit          in_frame = 1'b0;

    uart_tx_ctrl #(
      .DATA_W(DW), .PARITY_EN(PE), .PARITY_ODD(ODD), .STOP_BITS(SB)
    ) dut (
      .clk                  (clk),
      .rst                  (rst[g]),
      .I_tx_data            (tx_data[g][DW-1:0]),
      .I_tx_valid           (valid[g]),
      .O_tx_ready           (ready[g]),
      .O_baudrate_tx_clk_en (en[g]),
      .I_baudrate_tx_clk    (tick[g]),
      .O_txd                (txd[g]),
      .O_tx_busy            (busy[g]),
      .O_tx_done            (done[g])
    );

    // Baudrate model: one tick every 16 clk while enabled, count cleared while disabled.
    assign tick[g] = ((en[g] === 1'b1) && (gen_cnt == 4'd15)) || inj_tick[g];

    always @(posedge clk) begin
      rst_q <= rst[g];
      if (en[g] !== 1'b1) gen_cnt <= 4'd0;
      else                gen_cnt <= gen_cnt + 4'd1;
      if (!rst[g] && valid[g] && ready[g]) exp_q.push_back(9'(tx_data[g][DW-1:0]));
    end

    // Monitor: compares {txd,en,busy,ready,done} every cycle against the expected frame.
    always @(negedge clk) begin
      act = {txd[g], en[g], busy[g], ready[g], done[g]};
      if (rst_q) begin
        in_frame = 1'b0;
        checkOutput(g, "reset values", 32'(act), 32'(5'b10010));
      end else begin
        if (!in_frame && busy[g] === 1'b1) begin
          if (exp_q.size() == 0) begin
            checkOutput(g, "frame without handshake", 0, 1);
          end else begin
            w  = exp_q.pop_front();
            fb = '1;
            fb[0] = 1'b0;
            for (int i = 0; i < DW; i++) fb[1 + i] = w[i];
            if (PE != 0) fb[1 + DW] = (($countones(w) % 2) == 1) ^ (ODD != 0);
            flen     = 1 + DW + PE + SB;
            cyc      = 0;
            in_frame = 1'b1;
          end
        end
        if (in_frame) begin
          if (cyc < flen * BIT_CLKS) begin
            checkOutput(g, $sformatf("frame word %0h cycle %0d", w, cyc),
                        32'(act), 32'({fb[cyc / BIT_CLKS], 4'b1100}));
          end else begin
            checkOutput(g, "done cycle", 32'(act), 32'(5'b10011));
            in_frame = 1'b0;
          end
          cyc++;
        end else begin
          checkOutput(g, "idle outputs", 32'(act), 32'(5'b10010));
        end
      end
      pending[g] = exp_q.size() + (in_frame ? 1 : 0);
    end
  end

  task automatic wait_handshake(input int idx, input bit in_done);
    bit got;
    bit ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      got = ready[idx];
      if (got && in_done) checkOutput(idx, "back-to-back accepted in done cycle", 32'(done[idx]), 1);
      inj_tick[idx] = got ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (got) begin
        ok = 1'b1;
        break;
      end
    end
    inj_tick[idx] = 1'b0;
    if (!ok) checkOutput(idx, "handshake timeout", 0, 1);
  endtask

  task automatic applyStimulus(input int idx, input logic [8:0] word,
                               input bit keep_valid, input bit in_done);
    valid[idx]   = 1'b1;
    tx_data[idx] = word;
    wait_handshake(idx, in_done);
    if (!keep_valid) valid[idx] = 1'b0;
  endtask

  // Scrambles the data bus and injects stray ticks only while the controller is idle.
  task automatic idle_gap(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      tx_data[idx]  = 9'($urandom);
      inj_tick[idx] = (busy[idx] == 1'b0) && (en[idx] == 1'b0) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    inj_tick[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    bit ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      #1;
      if (pending[idx] == 0 && busy[idx] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput(idx, "frame completion timeout", 0, 1);
  endtask

  task automatic run_instance(input int idx);
    case (idx)
      0: begin
        applyStimulus(0, 9'h0A5, 1'b0, 1'b0);
        idle_gap(0, 50);
        rst[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        idle_gap(0, 5);
        applyStimulus(0, 9'h055, 1'b0, 1'b0);
        wait_idle(0);
        applyStimulus(0, 9'h000, 1'b1, 1'b0);
        applyStimulus(0, 9'h081, 1'b0, 1'b1);
        wait_idle(0);
      end
      1, 2:    begin applyStimulus(idx, 9'h007, 1'b0, 1'b0); wait_idle(idx); end
      3:       begin applyStimulus(idx, 9'h0FF, 1'b0, 1'b0); wait_idle(idx); end
      default: begin applyStimulus(idx, 9'h05A, 1'b0, 1'b0); wait_idle(idx); end
    endcase
    for (int k = 0; k < 10; k++) begin
      idle_gap(idx, $urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) begin
        applyStimulus(idx, 9'($urandom), 1'b1, 1'b0);
        applyStimulus(idx, 9'($urandom), 1'b0, 1'b1);
      end else begin
        applyStimulus(idx, 9'($urandom), 1'b0, 1'b0);
      end
    end
    wait_idle(idx);
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst[g]      = 1'b1;
      valid[g]    = 1'b0;
      tx_data[g]  = 9'h0;
      inj_tick[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) rst[g] = 1'b0;
    $display("[TB] starting %0d parallel configurations", NI);
    fork
      run_instance(0);
      run_instance(1);
      run_instance(2);
      run_instance(3);
      run_instance(4);
    join
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    checks++;
    failures++;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
